// File: rtl/seven_seg_pkg.sv
// Shared segment definitions for the seven-segment scan controller.
// Bit order of every pattern is {g,f,e,d,c,b,a}, active-high (1 = segment lit).
package seven_seg_pkg;

    typedef logic [6:0] seg_pat_t;

    localparam int SEG_BIT_A = 0;
    localparam int SEG_BIT_B = 1;
    localparam int SEG_BIT_C = 2;
    localparam int SEG_BIT_D = 3;
    localparam int SEG_BIT_E = 4;
    localparam int SEG_BIT_F = 5;
    localparam int SEG_BIT_G = 6;

    localparam seg_pat_t SEG_0     = 7'h3F;
    localparam seg_pat_t SEG_1     = 7'h06;
    localparam seg_pat_t SEG_2     = 7'h5B;
    localparam seg_pat_t SEG_3     = 7'h4F;
    localparam seg_pat_t SEG_4     = 7'h66;
    localparam seg_pat_t SEG_5     = 7'h6D;
    localparam seg_pat_t SEG_6     = 7'h7D;
    localparam seg_pat_t SEG_7     = 7'h07;
    localparam seg_pat_t SEG_8     = 7'h7F;
    localparam seg_pat_t SEG_9     = 7'h6F;
    localparam seg_pat_t SEG_A     = 7'h77;
    localparam seg_pat_t SEG_B     = 7'h7C;
    localparam seg_pat_t SEG_C     = 7'h39;
    localparam seg_pat_t SEG_D     = 7'h5E;
    localparam seg_pat_t SEG_E     = 7'h79;
    localparam seg_pat_t SEG_F     = 7'h71;
    localparam seg_pat_t SEG_BLANK = 7'h00;

    // Maps an active-high pattern onto the pin polarity of the board.
    function automatic seg_pat_t seg_to_pin(input seg_pat_t pat, input logic active_low);
        return active_low ? ~pat : pat;
    endfunction

endpackage

// File: rtl/seven_seg_mux_ctrl_bcd_to_seg.sv
// Combinational nibble -> active-high segment pattern.
// SEVEN_SEG_HEX_DECODE_EN: codes 10..15 show A,b,C,d,E,F instead of blank.
module bcd_to_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    // Nibble decode table.
    always_comb begin
        seg_o = SEG_BLANK;
        case (nibble_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
`ifdef SEVEN_SEG_HEX_DECODE_EN
            4'd10:   seg_o = SEG_A;
            4'd11:   seg_o = SEG_B;
            4'd12:   seg_o = SEG_C;
            4'd13:   seg_o = SEG_D;
            4'd14:   seg_o = SEG_E;
            4'd15:   seg_o = SEG_F;
`else
            4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15: seg_o = SEG_BLANK;
`endif
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_seg_mux_ctrl.sv
// Time-division multiplexed seven-segment controller with shadowed BCD data,
// anti-ghosting blank window and leading-zero suppression (SEVEN_SEG_HEX_DECODE_EN in decoder).
module seven_seg_mux_ctrl
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 100000,
    parameter int BLANK_CYCLES   = 1000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    lz_suppress,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_TH = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic             SEG_LOW  = (SEG_ACTIVE_LOW != 0);
    localparam logic             AN_LOW   = (AN_ACTIVE_LOW != 0);
    localparam logic [6:0]       SEG_OFF  = seg_to_pin(SEG_BLANK, SEG_LOW);
    localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{AN_LOW}};

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_bcd_q;
    logic [NUM_DIGITS-1:0]   shadow_dp_q;
    logic                    lz_q;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_q, frame_d;

    logic [NUM_DIGITS-1:0]   an_sel_s;
    logic [NUM_DIGITS-1:0]   suppress_s;
    logic                    zero_run_s;
    logic [3:0]              cur_nib_s;
    logic                    cur_dp_s;
    logic                    cur_sup_s;
    logic [6:0]              pattern_s;

    // Prescaler and scan index next state; frame pulse on last-digit wrap.
    always_comb begin
        cnt_d   = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        frame_d = 1'b0;
        if (cnt_q == CNT_MAX) begin
            idx_d   = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
            frame_d = (idx_q == IDX_MAX);
        end else begin
            idx_d   = idx_q;
            frame_d = 1'b0;
        end
    end

    // Digit k is a leading zero when it and every digit above it read 0; digit 0 is exempt.
    always_comb begin
        suppress_s = '0;
        zero_run_s = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run_s    = zero_run_s & (shadow_bcd_q[4*k +: 4] == 4'd0);
            suppress_s[k] = lz_q & zero_run_s;
        end
    end

    // AND-OR mux of the currently scanned digit's data.
    always_comb begin
        an_sel_s  = '0;
        cur_nib_s = 4'd0;
        cur_dp_s  = 1'b0;
        cur_sup_s = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            an_sel_s[k] = (idx_q == IDX_W'(k));
            cur_nib_s   = cur_nib_s | (shadow_bcd_q[4*k +: 4] & {4{an_sel_s[k]}});
            cur_dp_s    = cur_dp_s | (shadow_dp_q[k] & an_sel_s[k]);
            cur_sup_s   = cur_sup_s | (suppress_s[k] & an_sel_s[k]);
        end
    end

    bcd_to_seg u_bcd_to_seg (
        .nibble_i (cur_nib_s),
        .seg_o    (pattern_s)
    );

    // Pin values: everything dark during the blank window at the start of a slot.
    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        dp_d  = SEG_LOW;
        if (cnt_q >= BLANK_TH) begin
            an_d  = AN_LOW ? ~an_sel_s : an_sel_s;
            seg_d = seg_to_pin(cur_sup_s ? SEG_BLANK : pattern_s, SEG_LOW);
            dp_d  = cur_dp_s ^ SEG_LOW;
        end else begin
            an_d  = AN_OFF;
            seg_d = SEG_OFF;
            dp_d  = SEG_LOW;
        end
    end

    // Scan counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    // Shadow capture so a display update is always atomic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_bcd_q <= '0;
            shadow_dp_q  <= '0;
            lz_q         <= 1'b0;
        end else if (load) begin
            shadow_bcd_q <= bcd_in;
            shadow_dp_q  <= dp_in;
            lz_q         <= lz_suppress;
        end else begin
            shadow_bcd_q <= shadow_bcd_q;
            shadow_dp_q  <= shadow_dp_q;
            lz_q         <= lz_q;
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_q    <= AN_OFF;
            seg_q   <= SEG_OFF;
            dp_q    <= SEG_LOW;
            frame_q <= 1'b0;
        end else begin
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            frame_q <= frame_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_tick = frame_q;

endmodule

// File: tb/tb_seven_seg_mux_ctrl.sv
// Scoreboard bench for seven_seg_mux_ctrl (4 digits, 8-cycle slots, 2 blank cycles, active-low).
// Expectations are stamped with the clock-edge count at which they must appear on the pins.
module tb_seven_seg_mux_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic        load;
    logic        lz_suppress;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_tick;

    seven_seg_mux_ctrl #(
        .NUM_DIGITS     (4),
        .REFRESH_DIV    (8),
        .BLANK_CYCLES   (2),
        .SEG_ACTIVE_LOW (1),
        .AN_ACTIVE_LOW  (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bcd_in      (bcd_in),
        .dp_in       (dp_in),
        .load        (load),
        .lz_suppress (lz_suppress),
        .seg         (seg),
        .dp          (dp),
        .an          (an),
        .frame_tick  (frame_tick)
    );

    typedef struct {
        string      tag;
        int         stamp;
        logic [3:0] an_e;
        logic [6:0] seg_e;
        logic       dp_e;
        logic       ft_e;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   base = 0;
    int   vectors = 0;
    int   miscompares = 0;

`ifdef SEVEN_SEG_HEX_DECODE_EN
    localparam logic [6:0] SEG_HEX_B = 7'h03;
`else
    localparam logic [6:0] SEG_HEX_B = 7'h7F;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares the pins against the expectation stamped for this edge count.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].stamp <= cyc) begin
            exp_t e;
            e = q.pop_front();
            vectors++;
            if (e.stamp < cyc) begin
                miscompares++;
                $display("FAIL %s: expectation for edge %0d not sampled (now %0d)", e.tag, e.stamp, cyc);
            end else if (an !== e.an_e || seg !== e.seg_e || dp !== e.dp_e || frame_tick !== e.ft_e) begin
                miscompares++;
                $display("FAIL %s: got an=%b seg=%h dp=%b ft=%b, expected an=%b seg=%h dp=%b ft=%b",
                         e.tag, an, seg, dp, frame_tick, e.an_e, e.seg_e, e.dp_e, e.ft_e);
            end
        end
    end

    task automatic goto(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_k(input string tag, input int k, input logic [3:0] an_e,
                            input logic [6:0] seg_e, input logic dp_e, input logic ft_e);
        exp_t e;
        e.tag   = $sformatf("%s_k%0d", tag, k);
        e.stamp = base + k;
        e.an_e  = an_e;
        e.seg_e = seg_e;
        e.dp_e  = dp_e;
        e.ft_e  = ft_e;
        q.push_back(e);
    endtask

    // Load lands on edge k, so new data is on the pins from edge k+1.
    task automatic load_at(input int k, input logic [15:0] b, input logic [3:0] d, input logic lz);
        goto(base + k - 1);
        bcd_in      = b;
        dp_in       = d;
        lz_suppress = lz;
        load        = 1'b1;
        goto(base + k);
        load        = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        bcd_in      = 16'h0000;
        dp_in       = 4'b0000;
        load        = 1'b0;
        lz_suppress = 1'b0;

        goto(2);
        base = 0;
        expect_k("reset", 2, 4'b1111, 7'h7F, 1'b1, 1'b0);
        goto(3);
        rst  = 1'b0;
        base = cyc;

        expect_k("rel", 1, 4'b1111, 7'h7F, 1'b1, 1'b0);
        expect_k("rel", 2, 4'b1111, 7'h7F, 1'b1, 1'b0);
        expect_k("rel", 3, 4'b1110, 7'h40, 1'b1, 1'b0);
        expect_k("rel", 8, 4'b1110, 7'h40, 1'b1, 1'b0);
        expect_k("rel", 9, 4'b1111, 7'h7F, 1'b1, 1'b0);
        expect_k("rel", 10, 4'b1111, 7'h7F, 1'b1, 1'b0);
        expect_k("rel", 11, 4'b1101, 7'h40, 1'b1, 1'b0);
        expect_k("scan", 13, 4'b1101, 7'h30, 1'b1, 1'b0);
        expect_k("scan", 16, 4'b1101, 7'h30, 1'b1, 1'b0);
        expect_k("scan", 17, 4'b1111, 7'h7F, 1'b1, 1'b0);
        expect_k("scan", 19, 4'b1011, 7'h24, 1'b1, 1'b0);
        expect_k("scan", 27, 4'b0111, 7'h79, 1'b1, 1'b0);
        expect_k("scan", 31, 4'b0111, 7'h79, 1'b1, 1'b0);
        expect_k("tick", 32, 4'b0111, 7'h79, 1'b1, 1'b1);
        expect_k("tick", 33, 4'b1111, 7'h7F, 1'b1, 1'b0);
        expect_k("scan", 35, 4'b1110, 7'h19, 1'b1, 1'b0);
        expect_k("atom", 43, 4'b1101, 7'h30, 1'b1, 1'b0);
        expect_k("atom", 51, 4'b1011, 7'h24, 1'b1, 1'b0);
        expect_k("tick", 63, 4'b0111, 7'h79, 1'b1, 1'b0);
        expect_k("tick", 64, 4'b0111, 7'h79, 1'b1, 1'b1);
        expect_k("tick", 65, 4'b1111, 7'h7F, 1'b1, 1'b0);
        expect_k("lat", 67, 4'b1110, 7'h19, 1'b1, 1'b0);
        expect_k("lat", 68, 4'b1110, 7'h19, 1'b1, 1'b0);
        expect_k("lat", 69, 4'b1110, 7'h78, 1'b0, 1'b0);
        expect_k("lat", 72, 4'b1110, 7'h78, 1'b0, 1'b0);
        expect_k("lat", 73, 4'b1111, 7'h7F, 1'b1, 1'b0);
        expect_k("lat", 75, 4'b1101, 7'h00, 1'b0, 1'b0);
        expect_k("lat", 83, 4'b1011, 7'h10, 1'b1, 1'b0);
        expect_k("lat", 91, 4'b0111, 7'h40, 1'b1, 1'b0);
        expect_k("tick", 96, 4'b0111, 7'h40, 1'b1, 1'b1);
        expect_k("lz", 100, 4'b1110, 7'h78, 1'b0, 1'b0);
        expect_k("lz", 101, 4'b1110, 7'h12, 1'b1, 1'b0);
        expect_k("lz", 107, 4'b1101, 7'h7F, 1'b1, 1'b0);
        expect_k("lz", 115, 4'b1011, 7'h7F, 1'b1, 1'b0);
        expect_k("lz", 123, 4'b0111, 7'h7F, 1'b1, 1'b0);
        expect_k("lz", 128, 4'b0111, 7'h7F, 1'b1, 1'b1);
        expect_k("lz", 131, 4'b1110, 7'h12, 1'b1, 1'b0);
        expect_k("lz0", 133, 4'b1110, 7'h40, 1'b1, 1'b0);
        expect_k("lz0", 139, 4'b1101, 7'h7F, 1'b1, 1'b0);
        expect_k("lzmid", 141, 4'b1101, 7'h40, 1'b1, 1'b0);
        expect_k("lzmid", 147, 4'b1011, 7'h30, 1'b0, 1'b0);
        expect_k("lzmid", 155, 4'b0111, 7'h7F, 1'b1, 1'b0);
        expect_k("lzmid", 160, 4'b0111, 7'h7F, 1'b1, 1'b1);
        expect_k("lzmid", 163, 4'b1110, 7'h40, 1'b1, 1'b0);
        expect_k("hexb", 165, 4'b1110, SEG_HEX_B, 1'b1, 1'b0);
        expect_k("hexb", 171, 4'b1101, 7'h40, 1'b1, 1'b0);
        expect_k("midrst", 179, 4'b1011, 7'h40, 1'b1, 1'b0);
        expect_k("midrst", 180, 4'b1111, 7'h7F, 1'b1, 1'b0);

        load_at(12, 16'h1234, 4'b0000, 1'b0);
        for (int k = 36; k <= 50; k++) begin
            goto(base + k);
            bcd_in = 16'h5555 ^ 16'(k * 16'h0F13);
            dp_in  = 4'(k);
        end
        load_at(68, 16'h0987, 4'b0011, 1'b0);
        load_at(100, 16'h0005, 4'b0000, 1'b1);
        load_at(132, 16'h0000, 4'b0000, 1'b1);
        load_at(140, 16'h0300, 4'b0100, 1'b1);
        load_at(164, 16'h000B, 4'b0000, 1'b0);

        // Assert reset between edges while digit 2 is lit; pins must go dark without a clock.
        goto(base + 180);
        #1;
        rst = 1'b1;
        goto(base + 182);
        rst  = 1'b0;
        base = cyc;

        expect_k("restart", 1, 4'b1111, 7'h7F, 1'b1, 1'b0);
        expect_k("restart", 2, 4'b1111, 7'h7F, 1'b1, 1'b0);
        expect_k("restart", 3, 4'b1110, 7'h40, 1'b1, 1'b0);
        expect_k("restart", 8, 4'b1110, 7'h40, 1'b1, 1'b0);
        expect_k("restart", 9, 4'b1111, 7'h7F, 1'b1, 1'b0);
        expect_k("restart", 11, 4'b1101, 7'h40, 1'b1, 1'b0);
        expect_k("restart", 19, 4'b1011, 7'h40, 1'b1, 1'b0);
        expect_k("restart", 27, 4'b0111, 7'h40, 1'b1, 1'b0);
        expect_k("restart", 32, 4'b0111, 7'h40, 1'b1, 1'b1);
        expect_k("restart", 33, 4'b1111, 7'h7F, 1'b1, 1'b0);

        goto(base + 40);
        for (int i = 0; i < 200 && q.size() > 0; i++) begin
            @(posedge clk);
        end
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL %s: expectation never checked (stamp %0d, now %0d)", e.tag, e.stamp, cyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
